// File: rtl/uart_packet_rx.sv
// -----------------------------------------------------------------------------
// uart_packet_rx
//   Receives serial characters from an asynchronous UART line and assembles
//   PACKET_BYTES of them into one packet. A packet is exposed on `storage`
//   only when every character of it was received without framing or parity
//   errors. A packet left incomplete for IDLE_TIMEOUT bit periods is dropped.
//
// Ports
//   clk           in   system clock, rising-edge active
//   rst           in   asynchronous, active-high reset
//   uart_data     in   asynchronous serial line, idle high
//   storage       out  last complete packet; first character in the MS slot
//   is_data_ready out  one-cycle pulse when storage is updated
//   frame_error   out  one-cycle pulse when a stop bit is sampled low
//   parity_error  out  one-cycle pulse when a parity check fails
// -----------------------------------------------------------------------------
module uart_packet_rx #(
    parameter int CLK_PER_BIT  = 16,
    parameter int DATA_BITS    = 8,
    parameter int PACKET_BYTES = 2,
    parameter int PARITY       = 0,   // 0 none, 1 odd, 2 even
    parameter int MSB_FIRST    = 1,
    parameter int IDLE_TIMEOUT = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              uart_data,
    output logic [PACKET_BYTES*DATA_BITS-1:0] storage,
    output logic                              is_data_ready,
    output logic                              frame_error,
    output logic                              parity_error
);

    localparam int HALF_BIT     = CLK_PER_BIT / 2;
    localparam int TIMEOUT_CLKS = IDLE_TIMEOUT * CLK_PER_BIT;
    localparam int TW           = $clog2(CLK_PER_BIT);        // bit timer: 0..CLK_PER_BIT-1
    localparam int BCW          = $clog2(DATA_BITS);          // data bit index: 0..DATA_BITS-1
    localparam int CW           = $clog2(PACKET_BYTES + 1);   // character count: 0..PACKET_BYTES
    localparam int ITW          = $clog2(TIMEOUT_CLKS + 1);   // idle timer: 0..TIMEOUT_CLKS
    localparam int PW           = PACKET_BYTES * DATA_BITS;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP
    } state_t;

    state_t               state;
    logic                 sync_0;
    logic                 sync_1;
    logic [1:0]           settle;      // fills with ones once sync_1 carries a real line sample
    logic                 line_prev;
    logic                 fall;
    logic [TW-1:0]        bit_timer;
    logic [BCW-1:0]       bit_count;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 par_flag;
    logic [CW-1:0]        char_count;
    logic [ITW-1:0]       idle_timer;
    logic [PW-1:0]        shadow;
    logic [PW-1:0]        shadow_next;

    // line_prev only tracks the line once the synchroniser holds real samples,
    // so a line that is already low when reset releases never looks like a
    // falling edge; it must go high and fall again first.
    assign fall = line_prev & ~sync_1;

    // Shadow buffer with the just-completed character dropped into its slot.
    // Slot 0 (first character) occupies the most-significant bits.
    always_comb begin
        // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
        shadow_next = shadow;
        for (int i = 0; i < PACKET_BYTES; i++) begin
            if (char_count == CW'(i)) begin
                shadow_next[(PACKET_BYTES-1-i)*DATA_BITS +: DATA_BITS] = shift_reg;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            // Synchroniser flops reset to the idle level of the line.
            sync_0        <= 1'b1;
            sync_1        <= 1'b1;
            settle        <= '0;
            line_prev     <= 1'b0;
            bit_timer     <= '0;
            bit_count     <= '0;
            shift_reg     <= '0;
            par_flag      <= 1'b0;
            char_count    <= '0;
            idle_timer    <= '0;
            // NOTE: the shadow buffer is a register bank, not a RAM, so it is reset with everything else.
            shadow        <= '0;
            storage       <= '0;
            is_data_ready <= 1'b0;
            frame_error   <= 1'b0;
            parity_error  <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
            sync_0        <= uart_data;
            sync_1        <= sync_0;
            settle        <= {settle[0], 1'b1};
            line_prev     <= settle[1] ? sync_1 : 1'b0;

            // Pulse outputs are high for exactly one cycle.
            is_data_ready <= 1'b0;
            frame_error   <= 1'b0;
            parity_error  <= 1'b0;

            if (state != IDLE) begin
                idle_timer <= '0;
            end

            case (state)
                IDLE: begin
                    bit_timer <= '0;
                    bit_count <= '0;
                    if (fall) begin
                        idle_timer <= '0;
                        state      <= START;
                    end else if (char_count != '0) begin
                        // A partial packet that stalls too long is dropped silently.
                        if (idle_timer == ITW'(TIMEOUT_CLKS - 1)) begin
                            idle_timer <= '0;
                            char_count <= '0;
                        end else begin
                            idle_timer <= idle_timer + 1'b1;
                        end
                    end else begin
                        idle_timer <= '0;
                    end
                end

                START: begin
                    par_flag <= 1'b0;
                    if (bit_timer == TW'(HALF_BIT - 1)) begin
                        bit_timer <= '0;
                        // A line back high at mid start bit was a glitch.
                        state     <= sync_1 ? IDLE : DATA;
                    end else begin
                        bit_timer <= bit_timer + 1'b1;
                    end
                end

                DATA: begin
                    if (bit_timer == TW'(CLK_PER_BIT - 1)) begin
                        bit_timer <= '0;
                        if (MSB_FIRST != 0) begin
                            shift_reg <= {shift_reg[DATA_BITS-2:0], sync_1};
                        end else begin
                            shift_reg <= {sync_1, shift_reg[DATA_BITS-1:1]};
                        end
                        if (bit_count == BCW'(DATA_BITS - 1)) begin
                            bit_count <= '0;
                            state     <= (PARITY != 0) ? PAR : STOP;
                        end else begin
                            bit_count <= bit_count + 1'b1;
                        end
                    end else begin
                        bit_timer <= bit_timer + 1'b1;
                    end
                end

                PAR: begin
                    if (bit_timer == TW'(CLK_PER_BIT - 1)) begin
                        bit_timer <= '0;
                        // Odd parity wants an odd total of ones over data plus parity bit.
                        par_flag  <= ((^shift_reg) ^ sync_1) != (PARITY == 1);
                        state     <= STOP;
                    end else begin
                        bit_timer <= bit_timer + 1'b1;
                    end
                end

                STOP: begin
                    if (bit_timer == TW'(CLK_PER_BIT - 1)) begin
                        // Back to IDLE at mid stop bit so a following start edge is not missed.
                        bit_timer <= '0;
                        state     <= IDLE;
                        if (!sync_1) begin
                            frame_error <= 1'b1;
                            char_count  <= '0;
                        end else if (par_flag) begin
                            parity_error <= 1'b1;
                            char_count   <= '0;
                        end else if (char_count == CW'(PACKET_BYTES - 1)) begin
                            shadow        <= shadow_next;
                            storage       <= shadow_next;
                            is_data_ready <= 1'b1;
                            char_count    <= '0;
                        end else begin
                            shadow     <= shadow_next;
                            char_count <= char_count + 1'b1;
                        end
                    end else begin
                        bit_timer <= bit_timer + 1'b1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
